// File: rtl/warp_regfile.sv
// ---------------------------------------------------------------------------
// warp_regfile
//   Per-warp, per-thread general register file. Answers rs1/rs2 reads from the
//   execution unit with one cycle of latency and commits rd writebacks under a
//   per-lane thread mask. After reset the storage is cleared one (warp, reg)
//   row per cycle by an INIT sweep; init_done rises once the sweep completes.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   read_en           read request (rd_warp_id, rs1_addr, rs2_addr sampled)
//   rs1_data/rs2_data per-lane read data, lane t at [t*DATA_W +: DATA_W]
//   rdata_valid       read data valid, one cycle per accepted read
//   rd_write_en       writeback strobe (wr_warp_id, rd_addr, rd_data, thread_mask)
//   init_done         1 once the INIT sweep has finished
//   addr_err          1-cycle pulse for any access to warp_id >= NUM_WARPS
//
// Rows are addressed as {warp_id, reg}; the 5-bit register fields tie
// NUM_REGS to 32.
// ---------------------------------------------------------------------------
module warp_regfile #(
  parameter int THREADS_PER_WARP = 32,
  parameter int NUM_WARPS        = 8,
  parameter int NUM_REGS         = 32,
  parameter int DATA_W           = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 read_en,
  input  logic [5:0]                           rd_warp_id,
  input  logic [4:0]                           rs1_addr,
  input  logic [4:0]                           rs2_addr,
  output logic [THREADS_PER_WARP*DATA_W-1:0]   rs1_data,
  output logic [THREADS_PER_WARP*DATA_W-1:0]   rs2_data,
  output logic                                 rdata_valid,
  input  logic                                 rd_write_en,
  input  logic [5:0]                           wr_warp_id,
  input  logic [4:0]                           rd_addr,
  input  logic [THREADS_PER_WARP*DATA_W-1:0]   rd_data,
  input  logic [THREADS_PER_WARP-1:0]          thread_mask,
  output logic                                 init_done,
  output logic                                 addr_err
);

  localparam int ROW_W = THREADS_PER_WARP * DATA_W;
  localparam int ROWS  = NUM_WARPS * NUM_REGS;
  localparam int RA_W  = $clog2(ROWS);
  localparam int WA_W  = $clog2(NUM_WARPS);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [RA_W-1:0]    sweep_q, sweep_d;
  logic               init_done_q, init_done_d;
  logic [ROW_W-1:0]   rs1_q, rs1_d;
  logic [ROW_W-1:0]   rs2_q, rs2_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [ROW_W-1:0]   mem_q [ROWS];

  logic               rd_oor_s, wr_oor_s, wr_fire_s;
  logic [RA_W-1:0]    rs1_row_s, rs2_row_s, wr_row_s;
  logic [ROW_W-1:0]   rs1_rd_s, rs2_rd_s;

  // Replace the lanes selected by mask with new data when the write hits the read row.
  function automatic logic [ROW_W-1:0] lane_merge(
    input logic [ROW_W-1:0]            old_row,
    input logic [ROW_W-1:0]            new_row,
    input logic [THREADS_PER_WARP-1:0] mask,
    input logic                        hit
  );
    logic [ROW_W-1:0] res;
    res = old_row;
    for (int t = 0; t < THREADS_PER_WARP; t++) begin
      if (hit && mask[t]) begin
        res[t*DATA_W +: DATA_W] = new_row[t*DATA_W +: DATA_W];
      end else begin
        res[t*DATA_W +: DATA_W] = old_row[t*DATA_W +: DATA_W];
      end
    end
    return res;
  endfunction

  assign rd_oor_s  = (rd_warp_id >= 6'(NUM_WARPS));
  assign wr_oor_s  = (wr_warp_id >= 6'(NUM_WARPS));
  // Writes to r0 or to a nonexistent warp never reach storage.
  assign wr_fire_s = rd_write_en & ~wr_oor_s & (rd_addr != 5'd0);
  assign rs1_row_s = {rd_warp_id[WA_W-1:0], rs1_addr};
  assign rs2_row_s = {rd_warp_id[WA_W-1:0], rs2_addr};
  assign wr_row_s  = {wr_warp_id[WA_W-1:0], rd_addr};

  // Read data path: r0 and out-of-range warps read as zero, same-cycle writes bypass.
  always_comb begin
    rs1_rd_s = '0;
    rs2_rd_s = '0;
    if (!rd_oor_s && (rs1_addr != 5'd0)) begin
      rs1_rd_s = lane_merge(mem_q[rs1_row_s], rd_data, thread_mask,
                            wr_fire_s && (wr_row_s == rs1_row_s));
    end else begin
      rs1_rd_s = '0;
    end
    if (!rd_oor_s && (rs2_addr != 5'd0)) begin
      rs2_rd_s = lane_merge(mem_q[rs2_row_s], rd_data, thread_mask,
                            wr_fire_s && (wr_row_s == rs2_row_s));
    end else begin
      rs2_rd_s = '0;
    end
  end

  // Next-state logic for the INIT/READY controller and the registered outputs.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + RA_W'(1);
        if (sweep_q == RA_W'(ROWS - 1)) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
        end
      end
      ST_READY: begin
        if (read_en) begin
          valid_d = 1'b1;
          rs1_d   = rs1_rd_s;
          rs2_d   = rs2_rd_s;
        end else begin
          valid_d = 1'b0;
        end
        // Read and write errors in one cycle collapse into a single pulse.
        err_d = (read_en & rd_oor_s) | (rd_write_en & wr_oor_s);
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Controller and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  // Storage: cleared row by row during INIT, masked lane writes in READY.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == ST_INIT)) begin
      mem_q[sweep_q] <= '0;
    end else if (rst_n && (state_q == ST_READY) && wr_fire_s) begin
      for (int t = 0; t < THREADS_PER_WARP; t++) begin
        if (thread_mask[t]) begin
          mem_q[wr_row_s][t*DATA_W +: DATA_W] <= rd_data[t*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rs1_data    = rs1_q;
  assign rs2_data    = rs2_q;
  assign rdata_valid = valid_q;
  assign init_done   = init_done_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_warp_regfile.sv
module tb_warp_regfile;

  localparam int T  = 32;
  localparam int DW = 32;
  localparam int RW = T * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          read_en;
  logic [5:0]    rd_warp_id;
  logic [4:0]    rs1_addr, rs2_addr;
  logic [RW-1:0] rs1_data, rs2_data;
  logic          rdata_valid;
  logic          rd_write_en;
  logic [5:0]    wr_warp_id;
  logic [4:0]    rd_addr;
  logic [RW-1:0] rd_data;
  logic [T-1:0]  thread_mask;
  logic          init_done;
  logic          addr_err;

  always #5 clk = ~clk;

  warp_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .read_en(read_en), .rd_warp_id(rd_warp_id), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rdata_valid(rdata_valid),
    .rd_write_en(rd_write_en), .wr_warp_id(wr_warp_id), .rd_addr(rd_addr),
    .rd_data(rd_data), .thread_mask(thread_mask),
    .init_done(init_done), .addr_err(addr_err)
  );

  typedef struct packed { logic v; logic e; logic id; } ctl_t;
  typedef struct packed { logic [RW-1:0] a; logic [RW-1:0] b; } rd_t;

  ctl_t          ctl_q[$];
  rd_t           data_q[$];
  logic [RW-1:0] model [256];
  int            init_cnt;
  int            n_cmp = 0;
  int            n_bad = 0;
  ctl_t          mon_c;
  rd_t           mon_d;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    int lane;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      lane = 0;
      for (int t = T - 1; t >= 0; t--)
        if (act[t*DW +: DW] !== exp[t*DW +: DW]) lane = t;
      $display("FAIL %s: lane %0d got %h expected %h at %0t", name, lane,
               act[lane*DW +: DW], exp[lane*DW +: DW], $time);
    end
  endtask

  function automatic logic [RW-1:0] fill_inc(input logic [DW-1:0] base);
    logic [RW-1:0] r;
    for (int t = 0; t < T; t++) r[t*DW +: DW] = base + DW'(t);
    return r;
  endfunction

  function automatic logic [RW-1:0] fill_const(input logic [DW-1:0] v);
    logic [RW-1:0] r;
    for (int t = 0; t < T; t++) r[t*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [RW-1:0] fill_rand();
    logic [RW-1:0] r;
    for (int t = 0; t < T; t++) r[t*DW +: DW] = $urandom;
    return r;
  endfunction

  // Drive one cycle of stimulus and push the expected response for the following edge.
  task automatic do_cycle(input logic rst, input logic re, input int rw, input int r1, input int r2,
                          input logic we, input int ww, input int rd,
                          input logic [RW-1:0] data, input logic [T-1:0] mask);
    ctl_t c;
    rd_t  d;
    logic rdy;
    @(negedge clk);
    rst_n       = rst;
    read_en     = re;
    rd_warp_id  = 6'(rw);
    rs1_addr    = 5'(r1);
    rs2_addr    = 5'(r2);
    rd_write_en = we;
    wr_warp_id  = 6'(ww);
    rd_addr     = 5'(rd);
    rd_data     = data;
    thread_mask = mask;
    c = '{v: 1'b0, e: 1'b0, id: 1'b0};
    if (!rst) begin
      init_cnt = 0;
      for (int i = 0; i < 256; i++) model[i] = '0;
    end else begin
      rdy = (init_cnt == 256);
      if (!rdy) init_cnt++;
      c.id = (init_cnt == 256);
      if (rdy) begin
        // Write first so a same-cycle read sees new masked lanes and old unmasked ones.
        if (we && ww < 8 && rd != 0)
          for (int t = 0; t < T; t++)
            if (mask[t]) model[ww*32 + rd][t*DW +: DW] = data[t*DW +: DW];
        if (re) begin
          d.a = (rw < 8) ? model[rw*32 + r1] : '0;
          d.b = (rw < 8) ? model[rw*32 + r2] : '0;
          data_q.push_back(d);
        end
        c.v = re;
        c.e = (re && rw >= 8) || (we && ww >= 8);
      end
    end
    ctl_q.push_back(c);
  endtask

  task automatic idle();
    do_cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 0, '0, '0);
  endtask

  task automatic count_init(input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      idle();
      @(posedge clk);
      #1;
      cnt++;
      if (init_done === 1'b1) break;
    end
    chk_int(name, cnt, 256);
  endtask

  // Monitor: compare control outputs every scheduled cycle, data whenever valid.
  always @(posedge clk) begin
    #1;
    if (ctl_q.size() > 0) begin
      mon_c = ctl_q.pop_front();
      chk_bit("rdata_valid", rdata_valid, mon_c.v);
      chk_bit("addr_err", addr_err, mon_c.e);
      chk_bit("init_done", init_done, mon_c.id);
    end
    if (rdata_valid === 1'b1) begin
      if (data_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: rdata_valid=1 with no read pending at %0t", $time);
      end else begin
        mon_d = data_q.pop_front();
        chk_vec("rs1_data", rs1_data, mon_d.a);
        chk_vec("rs2_data", rs2_data, mon_d.b);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; read_en = 1'b0; rd_warp_id = '0; rs1_addr = '0; rs2_addr = '0;
    rd_write_en = 1'b0; wr_warp_id = '0; rd_addr = '0; rd_data = '0; thread_mask = '0;
    init_cnt = 0;
    for (int i = 0; i < 256; i++) model[i] = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset_valid", rdata_valid, 1'b0);
    chk_bit("reset_init_done", init_done, 1'b0);
    chk_bit("reset_addr_err", addr_err, 1'b0);
    chk_vec("reset_rs1", rs1_data, '0);
    chk_vec("reset_rs2", rs2_data, '0);

    // T1: sweep length, then a read of warp 3 r7 returns zeros.
    count_init("t1_init_cycles");
    do_cycle(1'b1, 1'b1, 3, 7, 7, 1'b0, 0, 0, '0, '0);
    idle();

    // T2: masked write, then read back (lanes 0..15 = 0x1000+t, rest 0).
    do_cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, 2, 5, fill_inc(32'h1000), 32'h0000FFFF);
    do_cycle(1'b1, 1'b1, 2, 5, 0, 1'b0, 0, 0, '0, '0);
    do_cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, 2, 5, fill_const(32'h5A5A5A5A), 32'h0);
    do_cycle(1'b1, 1'b1, 2, 0, 5, 1'b0, 0, 0, '0, '0);

    // T3: full-mask bypass, then a partial-mask bypass on the same row.
    do_cycle(1'b1, 1'b1, 1, 9, 9, 1'b1, 1, 9, fill_const(32'hDEADBEEF), 32'hFFFFFFFF);
    do_cycle(1'b1, 1'b1, 1, 9, 8, 1'b1, 1, 9, fill_inc(32'h77770000), 32'h0F0F0F0F);
    do_cycle(1'b1, 1'b1, 1, 9, 9, 1'b1, 2, 9, fill_const(32'h12345678), 32'hFFFFFFFF);
    idle();

    // T4: r0 stays zero; out-of-range warps read zero and pulse addr_err once.
    do_cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, 0, 0, fill_const(32'hFFFFFFFF), 32'hFFFFFFFF);
    do_cycle(1'b1, 1'b1, 0, 0, 0, 1'b1, 0, 0, fill_const(32'hFFFFFFFF), 32'hFFFFFFFF);
    do_cycle(1'b1, 1'b1, 9, 5, 9, 1'b0, 0, 0, '0, '0);
    idle();
    do_cycle(1'b1, 1'b1, 63, 1, 2, 1'b1, 12, 3, fill_const(32'hCAFEF00D), 32'hFFFFFFFF);
    do_cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, 8, 4, fill_const(32'h1), 32'h1);
    do_cycle(1'b1, 1'b1, 7, 31, 31, 1'b0, 0, 0, '0, '0);
    // Back-to-back reads of every register in warp 2.
    for (int r = 0; r < 32; r++) do_cycle(1'b1, 1'b1, 2, r, 31 - r, 1'b0, 0, 0, '0, '0);
    idle();

    // T5: reset, writes during INIT, second reset at sweep cycle 100.
    do_cycle(1'b0, 1'b1, 2, 5, 9, 1'b1, 2, 5, '0, '0);
    for (int i = 0; i < 100; i++)
      do_cycle(1'b1, 1'b1, 2, 5, 9, 1'b1, 2, 5, fill_const(32'hFFFFFFFF), 32'hFFFFFFFF);
    do_cycle(1'b0, 1'b1, 9, 5, 9, 1'b1, 9, 5, fill_const(32'hFFFFFFFF), 32'hFFFFFFFF);
    count_init("t5_init_cycles");
    do_cycle(1'b1, 1'b1, 2, 5, 5, 1'b0, 0, 0, '0, '0);
    do_cycle(1'b1, 1'b1, 1, 9, 9, 1'b0, 0, 0, '0, '0);

    // T6: random traffic; small register range to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      logic [T-1:0] m;
      m = ($urandom_range(0, 7) == 0) ? '0 : T'($urandom);
      do_cycle(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 9), $urandom_range(0, 7),
               $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 9),
               $urandom_range(0, 7), fill_rand(), m);
    end

    idle();
    idle();
    @(posedge clk);
    #2;
    chk_int("ctl_queue_drained", ctl_q.size(), 0);
    chk_int("data_queue_drained", data_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
